// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl
// Sequences the AES-256 key-expansion datapath. A cipher key is latched into a
// 256-bit window, the external (combinational) expander is stepped once per
// cycle through rounds 0..NR, and each returned round key is written into a
// local key store. The store is served to the round pipeline through a
// registered read port with one cycle of latency.
//
// Handshake: a key transfer happens on a rising edge where key_valid and
// key_ready are both 1. key_ready depends only on controller state (never on
// key_valid). While key_ready is 0 an offered key is not consumed, so the
// source must hold key_valid/key_in until a transfer edge.
//
// NR must be <= 15 because the expander round index is 4 bits wide.
module aes_key_sched_ctrl #(
    parameter int NR    = 14,
    parameter int KEY_W = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_valid,
    output logic               key_ready,
    input  logic [KEY_W-1:0]   key_in,
    output logic [KEY_W-1:0]   exp_in,
    output logic [3:0]         exp_round,
    input  logic [KEY_W/2-1:0] exp_out,
    input  logic [3:0]         rk_addr,
    input  logic               rk_rd,
    output logic [KEY_W/2-1:0] rk_data,
    output logic               sched_done,
    output logic [1:0]         dbg_state_o
);

    localparam int         RK_W = KEY_W / 2;
    localparam logic [3:0] NR_L = 4'(NR);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_READY  = 2'd2
    } state_t;

    state_t             state_q;
    logic               key_ready_q;
    logic               sched_done_q;
    logic [KEY_W-1:0]   window_q;
    logic [3:0]         round_q;
    logic [3:0]         ctr_q;
    logic [RK_W-1:0]    rk_data_q;
    logic [RK_W-1:0]    store_q [NR+1];

    logic key_accept;
    assign key_accept = key_valid && key_ready_q;

    // Control FSM: key accept, per-round stepping, window update and registered status.
    // round_q mirrors ctr_q while expanding but keeps the last round index afterwards,
    // and the window is not shifted on the final round, so the expander inputs stay
    // frozen while idle or ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            key_ready_q  <= 1'b1;
            sched_done_q <= 1'b0;
            window_q     <= '0;
            round_q      <= '0;
            ctr_q        <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_READY: begin
                    if (key_accept) begin
                        window_q     <= key_in;
                        ctr_q        <= '0;
                        round_q      <= '0;
                        sched_done_q <= 1'b0;
                        key_ready_q  <= 1'b0;
                        state_q      <= S_EXPAND;
                    end
                end
                S_EXPAND: begin
                    if (ctr_q == NR_L) begin
                        state_q      <= S_READY;
                        sched_done_q <= 1'b1;
                        key_ready_q  <= 1'b1;
                        ctr_q        <= '0;
                    end else begin
                        // Rounds 0 and 1 just return the key halves; from round 2 on
                        // the newest four words slide into the window.
                        if (ctr_q >= 4'd2) begin
                            window_q <= {window_q[RK_W-1:0], exp_out};
                        end
                        ctr_q   <= ctr_q + 4'd1;
                        round_q <= ctr_q + 4'd1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    key_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Key store write: one round key per expansion cycle at the current round index.
    always_ff @(posedge clk) begin
        if (state_q == S_EXPAND) begin
            store_q[ctr_q] <= exp_out;
        end
    end

    // Registered read port: out-of-range indices read as zero, no strobe holds the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_data_q <= '0;
        end else if (rk_rd) begin
            rk_data_q <= (rk_addr <= NR_L) ? store_q[rk_addr] : '0;
        end
    end

    assign key_ready   = key_ready_q;
    assign sched_done  = sched_done_q;
    assign exp_in      = window_q;
    assign exp_round   = round_q;
    assign rk_data     = rk_data_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Testbench for aes_key_sched_ctrl: supplies a behavioural AES-256 expander,
// checks the FIPS-197 C.3 schedule, the multi-cycle corner cases and random
// keys against a word-level key-expansion reference model.
module tb_aes_key_sched_ctrl;

    localparam int NR = 14;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [255:0] key_in = '0;
    logic [255:0] exp_in;
    logic [3:0]   exp_round;
    logic [127:0] exp_out;
    logic [3:0]   rk_addr = '0;
    logic         rk_rd = 1'b0;
    logic [127:0] rk_data;
    logic         sched_done;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;

    logic [127:0] exp_q[$];
    logic [127:0] model_rd = '0;
    logic [31:0]  w_ref [0:59];

    typedef struct {
        logic         rd;
        logic [3:0]   addr;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [8];

    localparam logic [255:0] FIPS_KEY =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    aes_key_sched_ctrl #(.NR(NR), .KEY_W(256)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_in     (key_in),
        .exp_in     (exp_in),
        .exp_round  (exp_round),
        .exp_out    (exp_out),
        .rk_addr    (rk_addr),
        .rk_rd      (rk_rd),
        .rk_data    (rk_data),
        .sched_done (sched_done),
        .dbg_state_o(dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    // AES arithmetic helpers
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_f(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        if (x != 8'h00) begin
            for (int y = 1; y < 256; y++) begin
                if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
            end
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {sbox_f(t[31:24]), sbox_f(t[23:16]), sbox_f(t[15:8]), sbox_f(t[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] t);
        return {t[23:0], t[31:24]};
    endfunction

    function automatic logic [7:0] rcon_f(input int j);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 1; i < j; i++) r = gmul(r, 8'h02);
        return r;
    endfunction

    // Behavioural expander attached to the DUT: window + round -> next round key
    function automatic logic [127:0] expand_f(input logic [255:0] win, input logic [3:0] r);
        logic [31:0] t;
        logic [31:0] n0, n1, n2, n3;
        if (r == 4'd0) return win[255:128];
        if (r == 4'd1) return win[127:0];
        if (r[0] == 1'b0) t = sub_word(rot_word(win[31:0])) ^ {rcon_f(int'(r) / 2), 24'h0};
        else              t = sub_word(win[31:0]);
        n0 = win[255:224] ^ t;
        n1 = win[223:192] ^ n0;
        n2 = win[191:160] ^ n1;
        n3 = win[159:128] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    always_comb exp_out = expand_f(exp_in, exp_round);

    // Reference model: textbook word-by-word AES-256 key expansion
    task automatic build_ref(input logic [255:0] key);
        logic [31:0] t;
        for (int i = 0; i < 8; i++) w_ref[i] = key[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w_ref[i-1];
            if (i % 8 == 0)      t = sub_word(rot_word(t)) ^ {rcon_f(i / 8), 24'h0};
            else if (i % 8 == 4) t = sub_word(t);
            w_ref[i] = w_ref[i-8] ^ t;
        end
    endtask

    function automatic logic [127:0] rk_ref(input int i);
        return {w_ref[4*i], w_ref[4*i+1], w_ref[4*i+2], w_ref[4*i+3]};
    endfunction

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s act=%h req=%h", name, act, req);
        end
    endtask

    task automatic accept(input logic [255:0] key);
        chk("key_ready_before_accept", {255'd0, key_ready}, 256'd1);
        key_in    = key;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        chk("key_ready_after_accept", {255'd0, key_ready}, 256'd0);
        chk("sched_done_after_accept", {255'd0, sched_done}, 256'd0);
    endtask

    task automatic wait_done(input int pulse_at, input logic [255:0] other_key, output int n);
        n = 0;
        while (!sched_done && n < 40) begin
            if (n == pulse_at) begin
                key_in    = other_key;
                key_valid = 1'b1;
            end
            step();
            n++;
            if (key_valid) begin
                chk("key_ready_low_in_expand", {255'd0, key_ready}, 256'd0);
                chk("state_expand_on_pulse", {254'd0, dbg_state}, 256'd1);
                key_valid = 1'b0;
            end
        end
        chk("done_latency", 256'(n), 256'd15);
    endtask

    // Scoreboard read: expected value computed from the model, queued, then compared
    task automatic read_sb(input logic [3:0] addr, input logic rd);
        logic [127:0] e;
        if (rd) model_rd = (int'(addr) <= NR) ? rk_ref(int'(addr)) : '0;
        exp_q.push_back(model_rd);
        rk_addr = addr;
        rk_rd   = rd;
        step();
        rk_rd = 1'b0;
        e = exp_q.pop_front();
        chk($sformatf("read_addr%0d_rd%0d", addr, rd), {128'd0, rk_data}, {128'd0, e});
    endtask

    initial begin
        int n;
        logic [255:0] key_a, key_b, key_c, key_d, hold_win;

        vecs[0] = '{1'b1, 4'd0,  128'h000102030405060708090a0b0c0d0e0f};
        vecs[1] = '{1'b1, 4'd1,  128'h101112131415161718191a1b1c1d1e1f};
        vecs[2] = '{1'b1, 4'd2,  128'ha573c29fa176c498a97fce93a572c09c};
        vecs[3] = '{1'b1, 4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36};
        vecs[4] = '{1'b0, 4'd3,  128'h24fc79ccbf0979e9371ac23c6d68de36};
        vecs[5] = '{1'b1, 4'd15, 128'h0};
        vecs[6] = '{1'b0, 4'd2,  128'h0};
        vecs[7] = '{1'b1, 4'd2,  128'ha573c29fa176c498a97fce93a572c09c};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_key_ready", {255'd0, key_ready}, 256'd1);
        chk("rst_sched_done", {255'd0, sched_done}, 256'd0);
        chk("rst_exp_in", exp_in, 256'd0);
        chk("rst_exp_round", {252'd0, exp_round}, 256'd0);
        chk("rst_rk_data", {128'd0, rk_data}, 256'd0);
        chk("rst_state", {254'd0, dbg_state}, 256'd0);
        rst_n = 1'b1;
        step();

        // FIPS-197 C.3 key
        build_ref(FIPS_KEY);
        accept(FIPS_KEY);
        wait_done(-1, '0, n);
        chk("ready_state", {254'd0, dbg_state}, 256'd2);
        chk("hold_exp_round", {252'd0, exp_round}, 256'd14);
        hold_win = {w_ref[48], w_ref[49], w_ref[50], w_ref[51],
                    w_ref[52], w_ref[53], w_ref[54], w_ref[55]};
        chk("hold_exp_in", exp_in, hold_win);
        repeat (3) step();
        chk("hold_exp_round_later", {252'd0, exp_round}, 256'd14);
        chk("hold_exp_in_later", exp_in, hold_win);

        for (int i = 0; i < 8; i++) begin
            rk_rd   = vecs[i].rd;
            rk_addr = vecs[i].addr;
            step();
            rk_rd = 1'b0;
            chk($sformatf("fips_vec%0d", i), {128'd0, rk_data}, {128'd0, vecs[i].exp});
        end

        // New key in READY with a same-cycle read of round 14
        key_b   = {$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()};
        key_in    = key_b;
        key_valid = 1'b1;
        rk_rd     = 1'b1;
        rk_addr   = 4'd14;
        step();
        key_valid = 1'b0;
        rk_rd     = 1'b0;
        chk("combo_old_rk14", {128'd0, rk_data}, {128'd0, 128'h24fc79ccbf0979e9371ac23c6d68de36});
        chk("combo_done_low", {255'd0, sched_done}, 256'd0);
        chk("combo_ready_low", {255'd0, key_ready}, 256'd0);
        build_ref(key_b);
        wait_done(-1, '0, n);
        read_sb(4'd14, 1'b1);
        read_sb(4'd5, 1'b1);

        // Different key offered mid-expansion is ignored
        key_c = {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()};
        key_d = ~key_c;
        build_ref(key_c);
        accept(key_c);
        wait_done(3, key_d, n);
        read_sb(4'd14, 1'b1);
        read_sb(4'd7, 1'b1);
        read_sb(4'd0, 1'b1);

        // Reset in the middle of an expansion, then a clean reload
        key_a = {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()};
        accept(key_a);
        repeat (6) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_done", {255'd0, sched_done}, 256'd0);
        chk("midrst_ready", {255'd0, key_ready}, 256'd1);
        chk("midrst_state", {254'd0, dbg_state}, 256'd0);
        chk("midrst_exp_round", {252'd0, exp_round}, 256'd0);
        chk("midrst_exp_in", exp_in, 256'd0);
        step();
        rst_n = 1'b1;
        model_rd = '0;
        build_ref(key_a);
        accept(key_a);
        wait_done(-1, '0, n);
        read_sb(4'd14, 1'b1);
        read_sb(4'd9, 1'b1);

        // Random keys with random reads
        for (int k = 0; k < 6; k++) begin
            key_a = {$urandom(), $urandom(), $urandom(), $urandom(),
                     $urandom(), $urandom(), $urandom(), $urandom()};
            build_ref(key_a);
            accept(key_a);
            wait_done(-1, '0, n);
            for (int j = 0; j < 20; j++) begin
                if (j == 0)       read_sb(4'($urandom_range(0, 14)), 1'b1);
                else if (j == 10) read_sb(4'd15, 1'b1);
                else              read_sb(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
